clock_freq_sampler: RTL and testbench



---
 rtl/clock_freq_sampler.sv | 114 +++++++++++
 tb/tb_clock_freq_sampler.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/clock_freq_sampler.sv
// Gated-window measurement controller for an external cross-clock cycle counter.
// Clears the counter, enables it for a programmed number of clk cycles, then captures the count.
module clock_freq_sampler #(
  parameter int unsigned COUNTER_WIDTH = 16,
  parameter int unsigned WINDOW_WIDTH  = 16,
  parameter int unsigned SETTLE_CYCLES = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [WINDOW_WIDTH-1:0]  window_cycles,
  output logic                     busy,
  output logic                     cnt_reset,
  output logic                     cnt_enable,
  input  logic [COUNTER_WIDTH-1:0] cnt_value,
  output logic                     result_valid,
  output logic [COUNTER_WIDTH-1:0] result_count,
  output logic                     result_overflow
);

  localparam int unsigned SettleBits = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned TimerWidth = (SettleBits > WINDOW_WIDTH) ? SettleBits : WINDOW_WIDTH;
  localparam logic [TimerWidth-1:0] SettleLoad = TimerWidth'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {StIdle, StClear, StRun, StSettle, StDone} state_e;

  state_e                   state_q;
  logic [TimerWidth-1:0]    timer_q;
  logic [WINDOW_WIDTH-1:0]  win_q;
  logic [COUNTER_WIDTH-1:0] prev_q;
  logic                     ovf_q;
  logic                     wrap;
  logic                     timer_done;

  // A sample lower than the previous one means the counter wrapped since the last cycle.
  assign wrap       = (cnt_value < prev_q);
  assign timer_done = (timer_q == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= StIdle;
      timer_q         <= '0;
      win_q           <= '0;
      prev_q          <= '0;
      ovf_q           <= 1'b0;
      busy            <= 1'b0;
      cnt_reset       <= 1'b1;
      cnt_enable      <= 1'b0;
      result_valid    <= 1'b0;
      result_count    <= '0;
      result_overflow <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            win_q           <= window_cycles;
            result_valid    <= 1'b0;
            result_count    <= '0;
            result_overflow <= 1'b0;
            ovf_q           <= 1'b0;
            timer_q         <= SettleLoad;
            busy            <= 1'b1;
            cnt_reset       <= 1'b1;
            cnt_enable      <= 1'b0;
            state_q         <= StClear;
          end
        end
        StClear: begin
          if (timer_done) begin
            prev_q    <= '0;
            cnt_reset <= 1'b0;
            if (win_q == '0) begin
              timer_q    <= SettleLoad;
              cnt_enable <= 1'b0;
              state_q    <= StSettle;
            end else begin
              timer_q    <= TimerWidth'(win_q) - TimerWidth'(1);
              cnt_enable <= 1'b1;
              state_q    <= StRun;
            end
          end else begin
            timer_q <= timer_q - 1'b1;
          end
        end
        StRun: begin
          prev_q <= cnt_value;
          if (wrap) ovf_q <= 1'b1;
          if (timer_done) begin
            timer_q    <= SettleLoad;
            cnt_enable <= 1'b0;
            state_q    <= StSettle;
          end else begin
            timer_q <= timer_q - 1'b1;
          end
        end
        StSettle: begin
          prev_q <= cnt_value;
          if (wrap) ovf_q <= 1'b1;
          if (timer_done) begin
            result_valid    <= 1'b1;
            result_count    <= cnt_value;
            result_overflow <= ovf_q | wrap;
            busy            <= 1'b0;
            state_q         <= StDone;
          end else begin
            timer_q <= timer_q - 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_clock_freq_sampler.sv
// Bench for clock_freq_sampler: two instances (16-bit and 8-bit counters) share stimulus and
// are each fed by a simple delayed-enable counter model.
module tb_clock_freq_sampler;

  localparam int unsigned S = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] window = '0;
  int unsigned rate = 1;

  logic        busy0, cnt_reset0, cnt_enable0, result_valid0, result_overflow0;
  logic [15:0] cnt0 = '0, result_count0;
  logic        busy1, cnt_reset1, cnt_enable1, result_valid1, result_overflow1;
  logic [7:0]  cnt1 = '0, result_count1;

  logic en0_p1 = 1'b0, en0_p2 = 1'b0, rst0_p1 = 1'b0, rst0_p2 = 1'b0;
  logic en1_p1 = 1'b0, en1_p2 = 1'b0, rst1_p1 = 1'b0, rst1_p2 = 1'b0;

  always #5 clk = ~clk;

  clock_freq_sampler #(
    .COUNTER_WIDTH(16), .WINDOW_WIDTH(16), .SETTLE_CYCLES(S)
  ) u_dut16 (
    .clk(clk), .reset(reset), .start(start), .window_cycles(window), .busy(busy0),
    .cnt_reset(cnt_reset0), .cnt_enable(cnt_enable0), .cnt_value(cnt0),
    .result_valid(result_valid0), .result_count(result_count0),
    .result_overflow(result_overflow0)
  );

  clock_freq_sampler #(
    .COUNTER_WIDTH(8), .WINDOW_WIDTH(16), .SETTLE_CYCLES(S)
  ) u_dut8 (
    .clk(clk), .reset(reset), .start(start), .window_cycles(window), .busy(busy1),
    .cnt_reset(cnt_reset1), .cnt_enable(cnt_enable1), .cnt_value(cnt1),
    .result_valid(result_valid1), .result_count(result_count1),
    .result_overflow(result_overflow1)
  );

  // Counter models: control inputs arrive two cycles late, count advances by `rate` per clk.
  always @(posedge clk) begin
    en0_p1 <= cnt_enable0; en0_p2 <= en0_p1; rst0_p1 <= cnt_reset0; rst0_p2 <= rst0_p1;
    if (rst0_p2) cnt0 <= '0;
    else if (en0_p2) cnt0 <= cnt0 + 16'(rate);
    en1_p1 <= cnt_enable1; en1_p2 <= en1_p1; rst1_p1 <= cnt_reset1; rst1_p2 <= rst1_p1;
    if (rst1_p2) cnt1 <= '0;
    else if (en1_p2) cnt1 <= cnt1 + 8'(rate);
  end

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic check(input string name, input longint actual, input longint expected);
    total_cnt++;
    if (actual == expected) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int unsigned lat0, lat1, en_cnt, busy_bad;
  longint      cap_c0, cap_o0, cap_c1, cap_o1;

  task automatic run_meas(input int unsigned win, input bit inject);
    int unsigned cyc;
    window = 16'(win);
    start  = 1'b1;
    tick();
    start  = 1'b0;
    window = 16'(win + 7);
    check("busy_after_start", longint'(busy0), 1);
    check("valid_drop_after_start", longint'(result_valid0), 0);
    cyc = 1; lat0 = 0; lat1 = 0; en_cnt = 0; busy_bad = 0;
    if (cnt_enable0) en_cnt++;
    while ((lat0 == 0 || lat1 == 0) && cyc < 2 * S + win + 60) begin
      if (inject && (cyc == S + 1 + win / 2 || cyc == 2 * S + win - 3)) start = 1'b1;
      tick();
      start = 1'b0;
      cyc++;
      if (cnt_enable0) en_cnt++;
      if (lat0 == 0 && !result_valid0 && !busy0) busy_bad++;
      if (lat0 == 0 && result_valid0) begin
        lat0 = cyc; cap_c0 = longint'(result_count0); cap_o0 = longint'(result_overflow0);
      end
      if (lat1 == 0 && result_valid1) begin
        lat1 = cyc; cap_c1 = longint'(result_count1); cap_o1 = longint'(result_overflow1);
      end
    end
  endtask

  task automatic verify(input int unsigned win, input int unsigned r);
    longint prod;
    prod = longint'(win) * longint'(r);
    check("latency16", lat0, 2 * S + win + 1);
    check("latency8", lat1, 2 * S + win + 1);
    check("enable_cycles", en_cnt, win);
    check("busy_gap", busy_bad, 0);
    check("count16", cap_c0, prod % 65536);
    check("ovf16", cap_o0, (prod >= 65536) ? 1 : 0);
    check("count8", cap_c1, prod % 256);
    check("ovf8", cap_o1, (prod >= 256) ? 1 : 0);
  endtask

  typedef struct {
    int unsigned win;
    int unsigned rate;
    bit          inject;
    int unsigned c0;
    bit          o0;
    int unsigned c1;
    bit          o1;
    int unsigned lat;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{100,  1, 1'b0, 100,  1'b0, 100, 1'b0, 133};
    vecs[1] = '{1000, 2, 1'b0, 2000, 1'b0, 208, 1'b1, 1033};
    vecs[2] = '{300,  1, 1'b0, 300,  1'b0, 44,  1'b1, 333};
    vecs[3] = '{0,    1, 1'b0, 0,    1'b0, 0,   1'b0, 33};
    vecs[4] = '{1,    1, 1'b0, 1,    1'b0, 1,   1'b0, 34};
    vecs[5] = '{255,  1, 1'b0, 255,  1'b0, 255, 1'b0, 288};
    vecs[6] = '{256,  1, 1'b0, 256,  1'b0, 0,   1'b1, 289};
    vecs[7] = '{60,   1, 1'b1, 60,   1'b0, 60,  1'b0, 93};

    // Reset state
    repeat (3) tick();
    check("rst_cnt_reset", longint'(cnt_reset0), 1);
    check("rst_cnt_enable", longint'(cnt_enable0), 0);
    check("rst_busy", longint'(busy0), 0);
    check("rst_valid", longint'(result_valid0), 0);
    check("rst_count", longint'(result_count0), 0);
    check("rst_ovf", longint'(result_overflow0), 0);
    reset = 1'b0;
    tick();

    foreach (vecs[i]) begin
      rate = vecs[i].rate;
      run_meas(vecs[i].win, vecs[i].inject);
      check("vec_latency16", lat0, vecs[i].lat);
      check("vec_latency8", lat1, vecs[i].lat);
      check("vec_enable_cycles", en_cnt, vecs[i].win);
      check("vec_busy_gap", busy_bad, 0);
      check("vec_count16", cap_c0, vecs[i].c0);
      check("vec_ovf16", cap_o0, vecs[i].o0);
      check("vec_count8", cap_c1, vecs[i].c1);
      check("vec_ovf8", cap_o1, vecs[i].o1);
      repeat (3) tick();
      check("done_hold_valid", longint'(result_valid0), 1);
      check("done_hold_count", longint'(result_count0), vecs[i].c0);
    end

    // Reset mid-RUN with a simultaneous start: reset wins.
    rate   = 1;
    window = 16'd100;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    repeat (S + 49) tick();
    check("midrun_enable", longint'(cnt_enable0), 1);
    reset = 1'b1;
    start = 1'b1;
    tick();
    reset = 1'b0;
    start = 1'b0;
    check("mrst_cnt_reset", longint'(cnt_reset0), 1);
    check("mrst_cnt_enable", longint'(cnt_enable0), 0);
    check("mrst_busy", longint'(busy0), 0);
    check("mrst_valid", longint'(result_valid0), 0);
    check("mrst_count", longint'(result_count0), 0);
    tick();
    check("mrst_start_dropped", longint'(busy0), 0);
    run_meas(20, 1'b0);
    verify(20, 1);

    // Randomized measurements against the arithmetic reference.
    for (int k = 0; k < 8; k++) begin
      int unsigned w;
      bit          inj;
      w    = $urandom_range(0, 400);
      rate = $urandom_range(1, 2);
      inj  = (w >= 8) ? 1'($urandom_range(0, 1)) : 1'b0;
      repeat ($urandom_range(0, 3)) tick();
      run_meas(w, inj);
      verify(w, rate);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
